// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - streams a program image into the MIPS32 core memory and holds the core until it is complete
// Writes are registered one cycle behind the accept; FLUSH drains the final write before DONE releases the core.

module mips32_prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int STOP_ON_HLT = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum,
    output logic [ADDR_W:0]   words_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     words_done_q, words_done_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                idle_like;
    logic                accept;
    logic                is_hlt;
    logic                is_last;
    logic [ADDR_W+1:0]   end_addr;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign accept    = in_valid && (state_q == S_LOAD);
    assign is_hlt    = (STOP_ON_HLT != 0) && (in_data[DATA_W-1 -: 6] == 6'b111111);
    assign is_last   = ((words_done_q + CW'(1)) == count_q) || is_hlt;
    // One bit of headroom so that an image ending exactly at the top of memory is legal
    assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        words_done_d = words_done_q;
        checksum_d   = checksum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = base_q + words_done_q[ADDR_W-1:0];
                    mem_wdata_d  = in_data;
                    checksum_d   = checksum_q + 32'(in_data);
                    words_done_d = words_done_q + CW'(1);
                    if (is_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                if (idle_like && start) begin
                    base_d       = base_addr;
                    count_d      = word_count;
                    words_done_d = '0;
                    checksum_d   = '0;
                    if (end_addr > MEM_WORDS) begin
                        state_d = S_ERR;
                    end else if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            words_done_q <= '0;
            checksum_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            words_done_q <= words_done_d;
            checksum_q   <= checksum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign cpu_hold   = (state_q != S_DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign checksum   = checksum_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - directed self-checking bench for mips32_prog_loader
// A shadow memory captures every mem_we so final images can be compared against the fed words.

module tb_mips32_prog_loader;

    logic        clk1;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;
    logic [10:0] words_done;

    mips32_prog_loader #(.ADDR_W(10), .DATA_W(32), .STOP_ON_HLT(1)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .words_done (words_done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic [31:0] tb_mem [0:1023];
    logic [31:0] words  [0:31];
    int          wr_cnt;
    logic        we_last_edge;
    int          checks;
    int          failures;

    always @(posedge clk1) begin
        we_last_edge = mem_we;
        if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] c);
        @(posedge clk1); #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input int n, input bit toggle);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = words[idx];
            @(negedge clk1);
            if (in_valid && in_ready) idx++;
            @(posedge clk1); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_accepts"}, 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk1);
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_we_before_done"}, 64'(we_last_edge), 64'd1);
        check({tag, "_hold_released"}, 64'(cpu_hold), 64'd0);
    endtask

    initial begin
        int          wr0;
        logic [31:0] sum;

        checks     = 0;
        failures   = 0;
        wr_cnt     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        for (int i = 0; i < 1024; i++) tb_mem[i] = '0;

        @(negedge clk1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we",   64'(mem_we),   64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_counters", {checksum, 21'd0, words_done}, 64'd0);
        @(posedge clk1); #1;
        rst_n = 1'b1;

        // 1: back-to-back three-word load
        words[0] = 32'h28010005;
        words[1] = 32'h28020007;
        words[2] = 32'h00221800;
        wr0 = wr_cnt;
        do_start(10'd0, 11'd3);
        check("t1_busy", 64'(busy), 64'd1);
        feed("t1", 3, 1'b0);
        wait_done("t1");
        check("t1_writes",   64'(wr_cnt - wr0), 64'd3);
        check("t1_mem0",     64'(tb_mem[0]), 64'h28010005);
        check("t1_mem1",     64'(tb_mem[1]), 64'h28020007);
        check("t1_mem2",     64'(tb_mem[2]), 64'h00221800);
        check("t1_checksum", 64'(checksum),  64'h5025180C);
        check("t1_words",    64'(words_done), 64'd3);

        // 2: same load with in_valid toggling; also start in DONE re-holds the core
        for (int i = 0; i < 3; i++) tb_mem[i] = '0;
        wr0 = wr_cnt;
        do_start(10'd0, 11'd3);
        check("t2_rehold", 64'(cpu_hold), 64'd1);
        check("t2_cleared", {checksum, 21'd0, words_done}, 64'd0);
        feed("t2", 3, 1'b1);
        wait_done("t2");
        check("t2_writes",   64'(wr_cnt - wr0), 64'd3);
        check("t2_mem0",     64'(tb_mem[0]), 64'h28010005);
        check("t2_mem1",     64'(tb_mem[1]), 64'h28020007);
        check("t2_mem2",     64'(tb_mem[2]), 64'h00221800);
        check("t2_checksum", 64'(checksum),  64'h5025180C);

        // 3: halt opcode ends the load early
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'hFC000000;
        words[3] = 32'h33333333;
        wr0 = wr_cnt;
        do_start(10'd200, 11'd8);
        feed("t3", 3, 1'b0);
        check("t3_ready_low", 64'(in_ready), 64'd0);
        wait_done("t3");
        check("t3_writes",   64'(wr_cnt - wr0), 64'd3);
        check("t3_words",    64'(words_done), 64'd3);
        check("t3_checksum", 64'(checksum), 64'h2F333333);
        check("t3_mem202",   64'(tb_mem[202]), 64'hFC000000);
        check("t3_mem203",   64'(tb_mem[203]), 64'h0);

        // 4: wrap rejected, then exact fit to the top of memory
        wr0 = wr_cnt;
        do_start(10'd1000, 11'd25);
        check("t4_err",  64'(err), 64'd1);
        check("t4_hold", 64'(cpu_hold), 64'd1);
        check("t4_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk1);
        #1;
        check("t4_no_writes", 64'(wr_cnt - wr0), 64'd0);
        sum = '0;
        for (int i = 0; i < 24; i++) begin
            words[i] = 32'h10000000 + 32'(i * 7);
            sum      = sum + words[i];
        end
        do_start(10'd1000, 11'd24);
        check("t4_err_clear", 64'(err), 64'd0);
        feed("t4", 24, 1'b0);
        wait_done("t4");
        check("t4_writes",   64'(wr_cnt - wr0), 64'd24);
        check("t4_checksum", 64'(checksum), 64'(sum));
        check("t4_mem1000",  64'(tb_mem[1000]), 64'(words[0]));
        check("t4_mem1023",  64'(tb_mem[1023]), 64'(words[23]));
        check("t4_err_end",  64'(err), 64'd0);

        // 5: zero-length load
        wr0 = wr_cnt;
        do_start(10'd5, 11'd0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_checksum", 64'(checksum), 64'd0);
        @(posedge clk1); #1;
        check("t5_no_writes", 64'(wr_cnt - wr0), 64'd0);

        // 6: ignored start during LOAD, then reset mid-load
        do_start(10'd100, 11'd5);
        in_valid = 1'b1;
        in_data  = 32'hAAAA0001;
        @(posedge clk1); #1;
        in_valid   = 1'b0;
        start      = 1'b1;
        base_addr  = 10'd500;
        word_count = 11'd1;
        @(posedge clk1); #1;
        start = 1'b0;
        check("t6_ignored_words", 64'(words_done), 64'd1);
        check("t6_ignored_busy",  64'(busy), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'hAAAA0002;
        @(posedge clk1); #1;
        in_valid = 1'b0;
        check("t6_we_live",  64'(mem_we), 64'd1);
        check("t6_addr",     64'(mem_addr), 64'd101);
        check("t6_words2",   64'(words_done), 64'd2);
        check("t6_mem100",   64'(tb_mem[100]), 64'hAAAA0001);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we",    64'(mem_we), 64'd0);
        check("t6_rst_hold",  64'(cpu_hold), 64'd1);
        check("t6_rst_state", 64'({busy, in_ready, done, err}), 64'd0);
        check("t6_rst_count", {checksum, 21'd0, words_done}, 64'd0);
        @(posedge clk1); #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
